// File: rtl/cong_don_nhan_cong.sv
// Frame accumulator downstream of nhan_cong: sums 9-bit beats until in_last, then holds the
// total, beat count and overflow flag until taken. Define CONG_DON_SATURATE_EN to clamp on overflow.
module cong_don_nhan_cong #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [ACC_W-1:0] SumMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic {StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             release_frame;
  logic [ACC_W:0]   add_full;
  logic             carry;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (accept && in_last) state_d = StHold;
      StHold:  if (out_ready)         state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // Handshake outputs depend on state only, so out_ready never reaches in_ready combinationally
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StAcc:   in_ready  = 1'b1;
      StHold:  out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  assign accept        = in_valid & in_ready;
  assign release_frame = out_valid & out_ready;

  assign add_full = {1'b0, sum_q} + {{(ACC_W - 8){1'b0}}, in_data};
  assign carry    = add_full[ACC_W];

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (release_frame) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
`ifdef CONG_DON_SATURATE_EN
      // Once clamped, the sum stays pinned at the maximum for the rest of the frame
      sum_d = (carry || ovf_q) ? SumMax : add_full[ACC_W-1:0];
`else
      sum_d = add_full[ACC_W-1:0];
`endif
      count_d = (count_q == CntMax) ? count_q : count_q + 1'b1;
      ovf_d   = ovf_q | carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cong_don_nhan_cong.sv
// Bench for cong_don_nhan_cong: a 16-bit and a 10-bit accumulator share one input stream and
// are checked against a frame-level model plus a table of hand-computed frames.
module tb_cong_don_nhan_cong;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        ir16, ov16, ovf16;
  logic [15:0] sum16;
  logic [7:0]  cnt16;
  logic        ir10, ov10, ovf10;
  logic [9:0]  sum10;
  logic [7:0]  cnt10;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: exact integer total of accepted beats
  bit     m_hold;
  longint m_cur, m_htot;
  int     m_n, m_hn;

  always #5 clk = ~clk;

  cong_don_nhan_cong u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir16),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (ov16),
    .out_ready (out_ready),
    .out_sum   (sum16),
    .out_count (cnt16),
    .out_ovf   (ovf16)
  );

  cong_don_nhan_cong #(.ACC_W(10), .CNT_W(8)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir10),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (ov10),
    .out_ready (out_ready),
    .out_sum   (sum10),
    .out_count (cnt10),
    .out_ovf   (ovf10)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_sum(input longint tot, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef CONG_DON_SATURATE_EN
    return (tot > mx) ? mx : tot;
`else
    return tot & mx;
`endif
  endfunction

  function automatic int exp_cnt(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_cur  = 0;
    m_htot = 0;
    m_n    = 0;
    m_hn   = 0;
  endtask

  task automatic check_model();
    longint tot;
    int     n;
    tot = m_hold ? m_htot : m_cur;
    n   = m_hold ? m_hn : m_n;
    chk("in_ready16", 64'(ir16), 64'(!m_hold));
    chk("in_ready10", 64'(ir10), 64'(!m_hold));
    chk("out_valid16", 64'(ov16), 64'(m_hold));
    chk("out_valid10", 64'(ov10), 64'(m_hold));
    chk("out_sum16", 64'(sum16), 64'(exp_sum(tot, 16)));
    chk("out_sum10", 64'(sum10), 64'(exp_sum(tot, 10)));
    chk("out_count16", 64'(cnt16), 64'(exp_cnt(n)));
    chk("out_count10", 64'(cnt10), 64'(exp_cnt(n)));
    chk("out_ovf16", 64'(ovf16), 64'(tot > 65535));
    chk("out_ovf10", 64'(ovf10), 64'(tot > 1023));
  endtask

  // Called at a negedge: drive inputs, advance the model across the coming edge, then check
  task automatic step(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = 9'(d);
    in_last   = l;
    out_ready = r;
    if (!m_hold) begin
      if (v) begin
        m_cur += d;
        m_n++;
        if (l) begin
          m_hold = 1'b1;
          m_htot = m_cur;
          m_hn   = m_n;
          m_cur  = 0;
          m_n    = 0;
        end
      end
    end else if (r) begin
      m_hold = 1'b0;
    end
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    int len;
    int d0, d1, d2, d3;
    int sum16;
    int sum10w;
    int sum10s;
    bit ovf10;
    int cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int beats[4];
    int s10;

    tbl[0] = '{3, 54, 84, 120, 0, 258, 258, 258, 1'b0, 3};
    tbl[1] = '{1, 450, 0, 0, 0, 450, 450, 450, 1'b0, 1};
    tbl[2] = '{3, 450, 450, 450, 0, 1350, 326, 1023, 1'b1, 3};
    tbl[3] = '{1, 5, 0, 0, 0, 5, 5, 5, 1'b0, 1};
    tbl[4] = '{2, 1, 2, 0, 0, 3, 3, 3, 1'b0, 2};
    tbl[5] = '{1, 3, 0, 0, 0, 3, 3, 3, 1'b0, 1};
    tbl[6] = '{2, 511, 511, 0, 0, 1022, 1022, 1022, 1'b0, 2};
    tbl[7] = '{3, 511, 511, 2, 0, 1024, 0, 1023, 1'b1, 3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    // Table of complete frames with out_ready high
    for (int t = 0; t < 8; t++) begin
      beats = '{tbl[t].d0, tbl[t].d1, tbl[t].d2, tbl[t].d3};
      for (int i = 0; i < tbl[t].len; i++) step(1'b1, beats[i], i == tbl[t].len - 1, 1'b1);
`ifdef CONG_DON_SATURATE_EN
      s10 = tbl[t].sum10s;
`else
      s10 = tbl[t].sum10w;
`endif
      chk("tbl_valid", 64'(ov16), 64'(1));
      chk("tbl_sum16", 64'(sum16), 64'(tbl[t].sum16));
      chk("tbl_sum10", 64'(sum10), 64'(s10));
      chk("tbl_ovf10", 64'(ovf10), 64'(tbl[t].ovf10));
      chk("tbl_ovf16", 64'(ovf16), 64'(0));
      chk("tbl_count", 64'(cnt16), 64'(tbl[t].cnt));
      step(1'b0, 0, 1'b0, 1'b1);
      chk("tbl_release_valid", 64'(ov16), 64'(0));
      chk("tbl_release_ready", 64'(ir16), 64'(1));
    end

    // Backpressure: result held, pending beat not consumed
    step(1'b1, 30, 1'b0, 1'b0);
    step(1'b1, 40, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7, 1'b0, 1'b0);
      chk("bp_sum", 64'(sum16), 64'(70));
      chk("bp_count", 64'(cnt16), 64'(2));
      chk("bp_in_ready", 64'(ir16), 64'(0));
    end
    step(1'b1, 7, 1'b1, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1);
    chk("bp_next_sum", 64'(sum16), 64'(7));
    chk("bp_next_count", 64'(cnt16), 64'(1));
    step(1'b0, 0, 1'b0, 1'b1);

    // Back-to-back with out_ready tied high: one bubble per frame
    step(1'b1, 1, 1'b0, 1'b1);
    chk("b2b_ready1", 64'(ir16), 64'(1));
    step(1'b1, 2, 1'b1, 1'b1);
    chk("b2b_res1_sum", 64'(sum16), 64'(3));
    chk("b2b_res1_cnt", 64'(cnt16), 64'(2));
    chk("b2b_bubble", 64'(ir16), 64'(0));
    step(1'b1, 3, 1'b1, 1'b1);
    chk("b2b_ready2", 64'(ir16), 64'(1));
    step(1'b1, 3, 1'b1, 1'b1);
    chk("b2b_res2_sum", 64'(sum16), 64'(3));
    chk("b2b_res2_cnt", 64'(cnt16), 64'(1));
    step(1'b0, 0, 1'b0, 1'b1);
    chk("b2b_ready3", 64'(ir16), 64'(1));

    // Reset mid-frame, with beats offered during reset
    step(1'b1, 100, 1'b0, 1'b1);
    step(1'b1, 200, 1'b0, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'd50;
    in_last  = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("rst_async_sum", 64'(sum16), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check_model();
    end
    rst_n = 1'b1;
    step(1'b1, 10, 1'b1, 1'b1);
    chk("rst_after_sum", 64'(sum16), 64'(10));
    chk("rst_after_cnt", 64'(cnt16), 64'(1));
    step(1'b0, 0, 1'b0, 1'b1);

    // Beat-count saturation
    for (int i = 0; i < 300; i++) step(1'b1, 1, i == 299, 1'b1);
    chk("cnt_sat", 64'(cnt16), 64'(255));
    chk("cnt_sat_sum", 64'(sum16), 64'(300));
    step(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 511)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
